// File: rtl/ram_arbiter.sv
`default_nettype none

// Word widths normally come from the project-wide defines.vh. The defaults
// below apply only when that file has not already defined them.
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef DATA_ADDR_W
`define DATA_ADDR_W 32
`endif

// ============================================================================
// Module      : ram_arbiter
// Description : Shares one RAM port between N_PORTS caches. A single
//               requester is chosen per 16-word line transfer using
//               round-robin priority. The module then sequences the burst
//               (a read refill or a write-back) on the RAM bus. It forwards
//               each beat's data between the RAM and the granted cache.
// Optional    : RAM_ARB_ATOMIC_LOCK_EN - lets an atomic requester keep the
//               RAM across bursts. The lock is released by the owner's next
//               non-atomic request, or after LOCK_MAX idle cycles without an
//               owner request.
// Ports       : clk, rst               clock, synchronous active-high reset
//               req_read/req_write     per-port line read / write request
//               req_atomic             per-port atomic flag (sampled at grant)
//               req_addr, req_data_w   per-port line address / write word
//               permit                 one-hot grant
//               beat                   current beat index
//               beat_ack, done         per-port beat / burst completion pulses
//               data_r                 registered read word
//               ram_*                  RAM-side address, strobes, data, stall
//               atomic_o               atomic lock held
// Revision    : 1.0  initial release
// ============================================================================
module ram_arbiter #(
    parameter int N_PORTS  = 2,
    parameter int PTR_W    = 1,
    parameter int LOCK_MAX = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_PORTS-1:0]               req_read,
    input  logic [N_PORTS-1:0]               req_write,
    input  logic [N_PORTS-1:0]               req_atomic,
    input  logic [N_PORTS*`DATA_ADDR_W-1:0]  req_addr,
    input  logic [N_PORTS*`DATA_W-1:0]       req_data_w,
    output logic [N_PORTS-1:0]               permit,
    output logic [3:0]                       beat,
    output logic [N_PORTS-1:0]               beat_ack,
    output logic [N_PORTS-1:0]               done,
    output logic [`DATA_W-1:0]               data_r,
    output logic [`DATA_ADDR_W-1:0]          ram_addr,
    output logic                             ram_read,
    output logic                             ram_write,
    output logic [`DATA_W-1:0]               ram_data_w,
    input  logic                             ram_wait,
    input  logic [`DATA_W-1:0]               ram_data_r,
    output logic                             atomic_o
);

    localparam int AW = `DATA_ADDR_W;
    localparam int DW = `DATA_W;
    localparam int LW = AW - 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [PTR_W-1:0]     r_owner;
    logic [LW-1:0]        r_line;
    logic                 r_dir;          // 1 = write-back, 0 = refill
    logic [PTR_W-1:0]     w_win;
    logic [LW-1:0]        w_win_line;
    logic                 w_win_write;
    logic                 w_any;
    logic                 w_lock;
    logic [N_PORTS-1:0]   w_elig;
    logic [N_PORTS-1:0]   w_own_mask;
    logic [DW-1:0]        w_own_data;
    logic                 w_unused;

    // ------------------------------------------------------------------
    // Arbitration and per-port muxing
    // ------------------------------------------------------------------
    always_comb begin
        w_own_mask = N_PORTS'(1) << r_owner;
        w_elig     = req_read | req_write;
        if (w_lock) begin
            w_elig = w_elig & w_own_mask;
        end
        w_any = |w_elig;

        // Pass 1 selects the lowest eligible port (the wrap-around case).
        // Pass 2 then overrides it with the lowest eligible port at or after
        // rr_ptr, if there is one.
        w_win = '0;
        for (int j = N_PORTS - 1; j >= 0; j--) begin
            if (w_elig[j]) begin
                w_win = PTR_W'(j);
            end
        end
        for (int j = N_PORTS - 1; j >= 0; j--) begin
            if (w_elig[j] && (PTR_W'(j) >= r_rr_ptr)) begin
                w_win = PTR_W'(j);
            end
        end

        w_win_line  = '0;
        w_win_write = 1'b0;
        w_own_data  = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            if (w_win == PTR_W'(j)) begin
                w_win_line  = req_addr[j*AW+4 +: LW];
                w_win_write = req_write[j];
            end
            if (r_owner == PTR_W'(j)) begin
                w_own_data = req_data_w[j*DW +: DW];
            end
        end
    end

    // Consumes inputs that are intentionally ignored: the word offset
    // within the line, and the atomic controls when locking is absent.
    always_comb begin
        w_unused = 1'b0;
        for (int j = 0; j < N_PORTS; j++) begin
            w_unused = w_unused ^ (^req_addr[j*AW +: 4]);
        end
`ifndef RAM_ARB_ATOMIC_LOCK_EN
        w_unused = w_unused ^ (^req_atomic) ^ (LOCK_MAX == 0);
`endif
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and RAM-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        ram_read    = 1'b0;
        ram_write   = 1'b0;
        ram_addr    = '0;
        ram_data_w  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                ram_read   = ~r_dir;
                ram_write  = r_dir;
                ram_addr   = {r_line, beat};
                ram_data_w = w_own_data;
                if (!ram_wait && (beat == 4'hF)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant, beat sequencing and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            permit   <= '0;
            beat     <= 4'd0;
            beat_ack <= '0;
            done     <= '0;
            data_r   <= '0;
            r_line   <= '0;
            r_dir    <= 1'b0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            beat_ack <= '0;
            done     <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        permit  <= N_PORTS'(1) << w_win;
                        r_owner <= w_win;
                        r_line  <= w_win_line;
                        r_dir   <= w_win_write;
                        beat    <= 4'd0;
                    end
                end
                S_BURST: begin
                    if (!ram_wait) begin
                        beat_ack <= w_own_mask;
                        data_r   <= ram_data_r;
                        beat     <= beat + 4'd1;
                        if (beat == 4'hF) begin
                            permit <= '0;
                            done   <= w_own_mask;
                        end
                    end
                end
                S_DONE: begin
                    // A held lock pins priority on the owner.
                    if (!w_lock) begin
                        r_rr_ptr <= (r_owner == PTR_W'(N_PORTS - 1)) ?
                                    '0 : r_owner + PTR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef RAM_ARB_ATOMIC_LOCK_EN
    // ------------------------------------------------------------------
    // Atomic lock
    // ------------------------------------------------------------------
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic          r_lock;
    logic [CW-1:0] r_idle_cnt;
    logic          w_win_atomic;

    always_comb begin
        w_win_atomic = 1'b0;
        for (int j = 0; j < N_PORTS; j++) begin
            if (w_win == PTR_W'(j)) begin
                w_win_atomic = req_atomic[j];
            end
        end
    end

    // Every grant re-samples the atomic flag. The owner therefore releases
    // the lock simply by making a non-atomic request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock     <= 1'b0;
            atomic_o   <= 1'b0;
            r_idle_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_any) begin
                r_lock     <= w_win_atomic;
                atomic_o   <= w_win_atomic;
                r_idle_cnt <= '0;
            end else if (r_lock) begin
                if (r_idle_cnt == CW'(LOCK_MAX - 1)) begin
                    r_lock     <= 1'b0;
                    atomic_o   <= 1'b0;
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + CW'(1);
                end
            end
        end
    end

    assign w_lock = r_lock;
`else
    assign w_lock   = 1'b0;
    assign atomic_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none

`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef DATA_ADDR_W
`define DATA_ADDR_W 32
`endif

module tb_ram_arbiter;

    logic                        clk;
    logic                        rst;
    logic [1:0]                  req_read;
    logic [1:0]                  req_write;
    logic [1:0]                  req_atomic;
    logic [2*`DATA_ADDR_W-1:0]   req_addr;
    logic [2*`DATA_W-1:0]        req_data_w;
    logic [1:0]                  permit;
    logic [3:0]                  beat;
    logic [1:0]                  beat_ack;
    logic [1:0]                  done;
    logic [`DATA_W-1:0]          data_r;
    logic [`DATA_ADDR_W-1:0]     ram_addr;
    logic                        ram_read;
    logic                        ram_write;
    logic [`DATA_W-1:0]          ram_data_w;
    logic                        ram_wait;
    logic [`DATA_W-1:0]          ram_data_r;
    logic                        atomic_o;

    int n_pass  = 0;
    int n_total = 0;

    ram_arbiter #(.N_PORTS(2), .PTR_W(1), .LOCK_MAX(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_atomic (req_atomic),
        .req_addr   (req_addr),
        .req_data_w (req_data_w),
        .permit     (permit),
        .beat       (beat),
        .beat_ack   (beat_ack),
        .done       (done),
        .data_r     (data_r),
        .ram_addr   (ram_addr),
        .ram_read   (ram_read),
        .ram_write  (ram_write),
        .ram_data_w (ram_data_w),
        .ram_wait   (ram_wait),
        .ram_data_r (ram_data_r),
        .atomic_o   (atomic_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM returns its address as data.
    assign ram_data_r = ram_addr;

    // Each cache supplies a per-port, per-beat write word.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            req_data_w[p*32 +: 32] = 32'hA000_0000 + 32'(p) * 32'h100 + {28'd0, beat};
        end
    end

    function automatic logic [31:0] exp_wdata(input int p, input int b);
        return 32'hA000_0000 + 32'(p) * 32'h100 + 32'(b & 15);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [31:0] addr;
        int          stall_a;
        int          stall_b;
        int          exp_port;
        logic        exp_wr;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[4];

    task automatic do_reset();
        rst        = 1'b1;
        req_read   = 2'b00;
        req_write  = 2'b00;
        req_atomic = 2'b00;
        ram_wait   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grant(output int port);
        int n;
        n = 0;
        port = -1;
        while (permit == 2'b00 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("grant_seen", 64'(permit != 2'b00), 64'd1);
        if (permit != 2'b00) port = permit[1] ? 1 : 0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 64'(done != 2'b00), 64'd1);
    endtask

    // Called at a negedge while the DUT is idle; that cycle counts as cycle 1.
    task automatic run_burst(input int idx);
        vec_t        v;
        logic [1:0]  pm;
        logic [31:0] ea;
        logic [31:0] last_a;
        int          cyc;
        int          b;
        int          st;
        bit          cmp;
        bit          fin;
        v  = vecs[idx];
        pm = 2'b01 << v.exp_port;
        for (int p = 0; p < 2; p++) begin
            req_addr[p*32 +: 32] = (p == v.exp_port) ? v.addr : ~v.addr;
        end
        req_read  = v.rd;
        req_write = v.wr;
        ram_wait  = 1'b0;
        cyc = 1; b = 0; st = 0; cmp = 1'b0; fin = 1'b0; last_a = '0;
        while (!fin && cyc < 60) begin
            @(negedge clk);
            cyc++;
            chk("beat_ack", 64'(beat_ack), cmp ? 64'(pm) : 64'd0);
            if (cmp) chk("data_r", 64'(data_r), 64'(last_a));
            cmp = 1'b0;
            if (done != 2'b00) begin
                fin = 1'b1;
                chk("done", 64'(done), 64'(pm));
                chk("done_cycle", 64'(cyc), 64'(v.exp_cycles));
                chk("done_permit", 64'(permit), 64'd0);
                chk("done_strobes", 64'({ram_read, ram_write}), 64'd0);
                req_read  = 2'b00;
                req_write = 2'b00;
            end else begin
                ea = {v.addr[31:4], 4'(b)};
                chk("permit", 64'(permit), 64'(pm));
                chk("ram_addr", 64'(ram_addr), 64'(ea));
                chk("ram_write", 64'(ram_write), 64'(v.exp_wr));
                chk("ram_read", 64'(ram_read), 64'(!v.exp_wr));
                if (v.exp_wr) chk("ram_data_w", 64'(ram_data_w), 64'(exp_wdata(v.exp_port, b)));
                if ((b == v.stall_a || b == v.stall_b) && st < 2) begin
                    ram_wait = 1'b1;
                    st++;
                end else begin
                    ram_wait = 1'b0;
                    cmp      = 1'b1;
                    last_a   = ea;
                    b++;
                    st = 0;
                end
            end
        end
        ram_wait = 1'b0;
        chk("burst_finished", 64'(fin), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int gnt_q[$];
        int gap_q[$];
        int zr;
        int port;
        int n;
        logic [1:0] pp;

        vecs[0] = '{rd: 2'b01, wr: 2'b00, addr: 32'h0001_2340, stall_a: -1, stall_b: -1,
                    exp_port: 0, exp_wr: 1'b0, exp_cycles: 18};
        vecs[1] = '{rd: 2'b00, wr: 2'b10, addr: 32'h0000_ABC0, stall_a: 3, stall_b: 7,
                    exp_port: 1, exp_wr: 1'b1, exp_cycles: 22};
        vecs[2] = '{rd: 2'b01, wr: 2'b01, addr: 32'hDEAD_BEEF, stall_a: -1, stall_b: -1,
                    exp_port: 0, exp_wr: 1'b1, exp_cycles: 18};
        vecs[3] = '{rd: 2'b10, wr: 2'b00, addr: 32'h0000_0010, stall_a: 0, stall_b: 15,
                    exp_port: 1, exp_wr: 1'b0, exp_cycles: 22};

        req_addr = '0;
        do_reset();

        // Reset state
        chk("rst_permit", 64'(permit), 64'd0);
        chk("rst_beat", 64'(beat), 64'd0);
        chk("rst_beat_ack", 64'(beat_ack), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_data_r", 64'(data_r), 64'd0);
        chk("rst_strobes", 64'({ram_read, ram_write}), 64'd0);
        chk("rst_atomic", 64'(atomic_o), 64'd0);

        // Table-driven single bursts
        for (int i = 0; i < 4; i++) begin
            run_burst(i);
            @(negedge clk);
            chk("gap_done", 64'(done), 64'd0);
            chk("gap_permit", 64'(permit), 64'd0);
            chk("gap_beat_ack", 64'(beat_ack), 64'd0);
        end

        // Both ports requesting continuously from reset
        do_reset();
        req_addr  = {32'h0000_2000, 32'h0000_1000};
        req_read  = 2'b11;
        zr = 0;
        pp = 2'b00;
        for (int c = 0; c < 120 && gnt_q.size() < 4; c++) begin
            @(negedge clk);
            if (permit != 2'b00 && pp == 2'b00) begin
                gnt_q.push_back(permit[1] ? 1 : 0);
                if (gnt_q.size() > 1) gap_q.push_back(zr);
            end
            if (permit == 2'b00) zr++;
            else zr = 0;
            pp = permit;
        end
        chk("rr_grant_count", 64'(gnt_q.size()), 64'd4);
        if (gnt_q.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("rr_order", 64'(gnt_q[k]), 64'(k % 2));
            for (int k = 0; k < 3; k++) chk("rr_gap", 64'(gap_q[k]), 64'd2);
        end

        // Reset in the middle of a burst
        do_reset();
        req_addr[31:0]  = 32'h0001_2340;
        req_addr[63:32] = 32'h0000_5670;
        req_read = 2'b01;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (beat != 4'd8 && n < 40);
        chk("reach_beat8", 64'(beat), 64'd8);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_permit", 64'(permit), 64'd0);
        chk("mid_rst_beat", 64'(beat), 64'd0);
        chk("mid_rst_beat_ack", 64'(beat_ack), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_data_r", 64'(data_r), 64'd0);
        chk("mid_rst_strobes", 64'({ram_read, ram_write}), 64'd0);
        chk("mid_rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("mid_rst_ram_data_w", 64'(ram_data_w), 64'd0);
        rst = 1'b0;
        req_read = 2'b10;
        @(negedge clk);
        chk("post_rst_grant", 64'(permit), 64'd2);
        chk("post_rst_addr", 64'(ram_addr), 64'h5670);
        wait_done();
        chk("post_rst_done", 64'(done), 64'd2);
        req_read = 2'b00;
        @(negedge clk);

`ifdef RAM_ARB_ATOMIC_LOCK_EN
        // Port 0 holds the lock until it makes a non-atomic request
        do_reset();
        req_read   = 2'b11;
        req_atomic = 2'b01;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) req_atomic = 2'b00;
            wait_grant(port);
            chk("lock_grant_port", 64'(port), 64'd0);
            chk("lock_atomic_o", 64'(atomic_o), (k < 2) ? 64'd1 : 64'd0);
            wait_done();
        end
        wait_grant(port);
        chk("unlock_grant_port", 64'(port), 64'd1);
        chk("unlock_atomic_o", 64'(atomic_o), 64'd0);
        wait_done();
        req_read = 2'b00;

        // Forced release after LOCK_MAX idle cycles
        do_reset();
        req_read   = 2'b01;
        req_atomic = 2'b01;
        wait_grant(port);
        chk("to_grant_port", 64'(port), 64'd0);
        chk("to_atomic_set", 64'(atomic_o), 64'd1);
        wait_done();
        req_read   = 2'b10;
        req_atomic = 2'b00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 64) chk("to_atomic_held", 64'(atomic_o), 64'd1);
            if (n == 65) chk("to_atomic_released", 64'(atomic_o), 64'd0);
        end while (permit == 2'b00 && n < 100);
        chk("to_release_cycle", 64'(n), 64'd66);
        chk("to_port1_grant", 64'(permit), 64'd2);
        wait_done();
        req_read = 2'b00;
`else
        // Without locking, the atomic flag has no effect on arbitration
        do_reset();
        req_read   = 2'b11;
        req_atomic = 2'b01;
        wait_grant(port);
        chk("noatomic_first", 64'(port), 64'd0);
        chk("noatomic_flag", 64'(atomic_o), 64'd0);
        wait_done();
        wait_grant(port);
        chk("noatomic_second", 64'(port), 64'd1);
        chk("noatomic_flag2", 64'(atomic_o), 64'd0);
        wait_done();
        req_read   = 2'b00;
        req_atomic = 2'b00;
`endif
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single RAM port between `N_PORTS` cache instances of the multicore processor. It selects one requesting cache per line transfer with round-robin priority and sequences the 16-word line burst (read refill or write-back) on the RAM bus. It forwards each beat's data between the RAM and the granted cache, and optionally holds the RAM for a cache performing an atomic sequence. It sits between the per-core caches and the RAM model; word widths come from `defines.vh` (`` `DATA_W ``, `` `DATA_ADDR_W ``).

## Interface
- `N_PORTS`, 2, number of cache requesters (2..8)
- `PTR_W`, 1, width of port index, ≥ clog2(`N_PORTS`)
- `LOCK_MAX`, 64, idle cycles after which an atomic lock is force-released
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_read`  in  N_PORTS  per-port line-read request
- `req_write`  in  N_PORTS  per-port line-write request
- `req_atomic`  in  N_PORTS  per-port atomic flag, sampled at grant
- `req_addr`  in  N_PORTS*`` `DATA_ADDR_W ``  per-port line address; bits [3:0] ignored
- `req_data_w`  in  N_PORTS*`` `DATA_W ``  per-port write word for current beat
- `permit`  out  N_PORTS  one-hot grant; 0 when idle
- `beat`  out  4  index of current beat (shared)
- `beat_ack`  out  N_PORTS  one-cycle pulse to granted port per completed beat
- `done`  out  N_PORTS  one-cycle pulse after beat 15 completes
- `data_r`  out  `` `DATA_W ``  registered read word, valid with `beat_ack`
- `ram_addr`  out  `` `DATA_ADDR_W ``  {line[31:4], beat}
- `ram_read`, `ram_write`  out  1  RAM strobes
- `ram_data_w`  out  `` `DATA_W ``  write word from granted port
- `ram_wait`  in  1  RAM stall; beat completes on a cycle with `ram_wait`==0
- `ram_data_r`  in  `` `DATA_W ``  RAM read word
- `atomic_o`  out  1  high while an atomic lock is held

## Operation
- States: IDLE, BURST, DONE.
- IDLE: eligible ports = ports with `req_read|req_write`. When locked, only the lock owner is eligible. Winner = first eligible port at or after `rr_ptr`, wrapping. The grant registers `permit`, `line`, `dir` (write if `req_write`, since write beats read on the same port), and `owner`, and clears `beat`. Next state is BURST. With no eligible port, the state stays IDLE.
- BURST: `ram_read`/`ram_write` driven per `dir`. `ram_addr`={line[31:4],beat}. `ram_data_w` muxed combinationally from `req_data_w[owner]`. On a cycle with `ram_wait`==0:
  - `beat_ack[owner]` pulses next cycle.
  - `data_r`←`ram_data_r`.
  - `beat`++.
  - At beat 15, the state goes to DONE.
- DONE: one cycle. `permit`=0, RAM strobes=0, `done[owner]`=1, `rr_ptr`←owner+1 mod N_PORTS. Requests are ignored this cycle, and a requester must deassert on `done`. Next state is IDLE.
- Requests that change during BURST are ignored; `line` and `dir` are frozen at grant.
- Reset: all outputs 0, `rr_ptr`=0, lock cleared, state IDLE. Reset mid-burst aborts the burst with no `done` pulse.

## Timing
- Request seen in IDLE → `permit` and strobes high the next cycle.
- Minimum burst with no stalls is 16 BURST cycles plus 1 DONE, so 18 cycles request-to-`done`.
- Back-to-back grants are separated by the DONE cycle plus the IDLE cycle (2-cycle gap).
- `ram_wait` may stall any beat indefinitely. The address and data stay stable while stalled.
- `permit` stays stable for the whole of BURST.

## Configuration
- `RAM_ARB_ATOMIC_LOCK_EN` defined:
  - A grant with `req_atomic[owner]`=1 sets the lock and `atomic_o`=1 from BURST entry.
  - After DONE, only the owner may be granted.
  - The lock clears when the owner presents a request with `req_atomic`=0; that burst is still granted, and `atomic_o` falls at its grant.
  - The lock also clears after `LOCK_MAX` consecutive IDLE cycles with no owner request.
  - `rr_ptr` does not advance while locked.
- Undefined: `req_atomic` ignored, `atomic_o` tied 0, and pure round-robin applies.

## Test plan
- Single read, port 0, line 0x0001_2340, `ram_wait`=0, RAM returns addr-as-data:
  - 16 `beat_ack` pulses with `data_r`=0x12340..0x1234F.
  - `done[0]` on cycle 18.
- Ports 0 and 1 both request continuously from reset:
  - Grant order is 0,1,0,1.
  - 2-cycle gap between bursts.
- Write burst on port 1 with `ram_wait` high on beats 3 and 7 for 2 cycles each:
  - `ram_addr`/`ram_data_w` held during stalls.
  - `done` on cycle 22.
- `req_read` and `req_write` both high on port 0:
  - `ram_write`=1.
  - `ram_read`=0 throughout.
- `rst` asserted at beat 8:
  - All outputs 0 next cycle.
  - New request from port 1 is granted first.
- Macro on, port 0 atomic, port 1 requesting:
  - Port 0 re-granted until its non-atomic request.
  - Lock force-released after 64 idle cycles; then port 1 granted.
